// File: rtl/bcd_pkg.sv
// Shared types, constants and sizing helpers for the serial binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Bit count of the step counter, which must hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Smallest digit count whose decimal range covers 2^width - 1.
  function automatic int unsigned min_digits(input int unsigned width);
    logic [127:0] max_v;
    logic [127:0] pow_v;
    int unsigned  d;
    max_v = (128'(1) << width) - 128'(1);
    pow_v = 128'd10;
    d     = 1;
    for (int i = 0; i < 38; i++) begin
      if (pow_v <= max_v) begin
        pow_v = pow_v * 128'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble adjust cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/bcd_serial_converter.sv
// Sequential double-dabble converter: one operand bit per clock, one conversion in flight,
// valid/ready handshakes on both sides.
module bcd_serial_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "bcd_serial_converter: WIDTH must be at least 1");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $fatal(1, "bcd_serial_converter: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;

  // One shared row of adjust cells, reused on every shift step.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    out_bcd_d = out_bcd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_bcd_d = bcd_shift;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      out_bcd_q <= out_bcd_d;
    end
  end

  // Handshake flags decode from the state register only; in_ready is also masked by reset.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Self-checking bench for bcd_serial_converter (WIDTH=16, DIGITS=5) against a decimal reference.
module tb_bcd_serial_converter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] out_bcd;
  logic                busy;

  int tests = 0;
  int fails = 0;

  bcd_serial_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Decimal reference: peel off base-10 digits with plain arithmetic.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operand and wait (bounded) for out_valid; returns cycles from acceptance.
  task automatic launch(input logic [WIDTH-1:0] v, output int lat);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [WIDTH-1:0] v);
    int lat;
    launch(v, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(WIDTH));
    chk({tag, "_bcd"}, 64'(out_bcd), 64'(to_bcd(int'(v))));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int sent, recv, last_hs, cyc;
    logic [4*DIGITS-1:0] held, exp_q[$];
    logic acc, hs;
    logic [4*DIGITS-1:0] bcd_s;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_bcd", 64'(out_bcd), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Directed corner operands.
    convert("zero", 16'd0);
    convert("max", 16'd65535);
    chk("max_lit", 64'(to_bcd(65535)), 64'h65535);
    convert("n9999", 16'd9999);
    convert("one", 16'd1);

    // Small-value sweep, 0..31.
    for (int v = 0; v < 32; v++) convert("sweep", 16'(v));

    // Back-pressure: stall with out_ready low and in_valid pulses that must be ignored.
    launch(16'd4242, lat);
    chk("bp_lat", 64'(lat), 64'(WIDTH));
    held = out_bcd;
    chk("bp_bcd", 64'(held), 64'(to_bcd(4242)));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = 16'($urandom);
      tick();
      chk("bp_stable", 64'(out_bcd), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("bp_idle_busy", 64'(busy), 64'd0);
    convert("bp_next", 16'd777);

    // Back-to-back stream of random operands.
    sent = 0; recv = 0; last_hs = -1; cyc = 0;
    in_data = 16'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (recv < 100 && cyc < 100 * 18 + 100) begin
      acc   = in_valid && in_ready;
      hs    = out_valid && out_ready;
      bcd_s = out_bcd;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(to_bcd(int'(in_data)));
        sent++;
        in_data = 16'($urandom);
        if (sent == 100) in_valid = 1'b0;
      end
      if (hs) begin
        if (exp_q.size() == 0) chk("b2b_extra", 64'd1, 64'd0);
        else chk("b2b_data", 64'(bcd_s), 64'(exp_q.pop_front()));
        if (last_hs >= 0) chk("b2b_period", 64'(cyc - last_hs), 64'(WIDTH + 2));
        last_hs = cyc;
        recv++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 64'(recv), 64'd100);
    chk("b2b_left", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset during the 7th shift step.
    in_data = 16'd12345;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rs_no_valid", 64'(out_valid), 64'd0);
    end
    convert("rs_next", 16'd4321);
    chk("rs_lit", 64'(to_bcd(4321)), 64'h04321);

    // Reset while holding a result in DONE.
    launch(16'd31415, lat);
    chk("rd_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rd_out_valid", 64'(out_valid), 64'd0);
    chk("rd_out_bcd", 64'(out_bcd), 64'd0);
    chk("rd_busy", 64'(busy), 64'd0);
    tick();
    convert("rd_next", 16'd50000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
